// File: rtl/otter_pkg.sv
// Shared types for the OTTER execute stage: ALU op codes, jump kinds, branch
// funct3 values, multiplier FSM states and the branch-condition helper.
package otter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101,
    ALU_MUL  = 4'b1111
  } alu_fun_t;

  typedef enum logic [1:0] {
    JUMP_NONE   = 2'b00,
    JUMP_BRANCH = 2'b01,
    JUMP_JAL    = 2'b10,
    JUMP_JALR   = 2'b11
  } jump_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // Reserved funct3 encodings resolve as not taken.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_state_if.sv
// Decode-register inputs and Memory_State-facing outputs of the execute stage.
// master = surrounding pipeline (drives DR_*), slave = execute_state.
interface execute_state_if;
  logic        DR_VALID;
  logic [31:0] DR_IR;
  logic [31:0] DR_PC;
  logic [31:0] DR_RS1;
  logic [31:0] DR_RS2;
  logic [31:0] DR_IMM;
  logic [3:0]  DR_ALU_FUN;
  logic [1:0]  DR_SRC_SEL;
  logic [1:0]  DR_JUMP;
  logic        DR_memWrite;
  logic        DR_memRead2;
  logic        DR_REG_WRITE;
  logic [1:0]  DR_RF_WR_SEL;
  logic [4:0]  DR_RD;

  logic        ER_memWrite;
  logic        ER_memRead2;
  logic        ER_REG_WRITE;
  logic [31:0] ER_PC_MEM;
  logic [31:0] ER_PC_4;
  logic [31:0] ER_ALU_OUT;
  logic [31:0] ER_RS2;
  logic [1:0]  ER_RF_WR_SEL;
  logic [4:0]  EX_MS_RD;
  logic        EX_REDIRECT;
  logic [31:0] EX_TARGET;
  logic        EX_BUSY;

  modport master (
    output DR_VALID, DR_IR, DR_PC, DR_RS1, DR_RS2, DR_IMM, DR_ALU_FUN,
           DR_SRC_SEL, DR_JUMP, DR_memWrite, DR_memRead2, DR_REG_WRITE,
           DR_RF_WR_SEL, DR_RD,
    input  ER_memWrite, ER_memRead2, ER_REG_WRITE, ER_PC_MEM, ER_PC_4,
           ER_ALU_OUT, ER_RS2, ER_RF_WR_SEL, EX_MS_RD, EX_REDIRECT,
           EX_TARGET, EX_BUSY
  );

  modport slave (
    input  DR_VALID, DR_IR, DR_PC, DR_RS1, DR_RS2, DR_IMM, DR_ALU_FUN,
           DR_SRC_SEL, DR_JUMP, DR_memWrite, DR_memRead2, DR_REG_WRITE,
           DR_RF_WR_SEL, DR_RD,
    output ER_memWrite, ER_memRead2, ER_REG_WRITE, ER_PC_MEM, ER_PC_4,
           ER_ALU_OUT, ER_RS2, ER_RF_WR_SEL, EX_MS_RD, EX_REDIRECT,
           EX_TARGET, EX_BUSY
  );
endinterface

// File: rtl/otter_alu.sv
// Combinational RV32I ALU; undefined op codes (including MUL) produce 0.
module otter_alu
  import otter_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  alu_fun,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  always_comb begin
    result = '0;
    case (alu_fun)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLL:  result = src_a << shamt;
      ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: result = {31'd0, src_a < src_b};
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_LUI:  result = src_b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_state.sv
// OTTER RV32I execute stage: ALU, branch/jump redirect with self-squash, and
// the EX->MEM register. Define OTTER_EX_MUL_EN to add the iterative multiplier.
module execute_state
  import otter_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 1
)
(
  input  logic      EX_CLOCK,
  input  logic      EX_RESET_N,
  execute_state_if.slave ex
);

  if (MUL_BITS_PER_CYCLE != 1 && MUL_BITS_PER_CYCLE != 2 && MUL_BITS_PER_CYCLE != 4) begin : g_bad_mul_bits
    $error("MUL_BITS_PER_CYCLE must be 1, 2 or 4");
  end

  logic [31:0] src_a, src_b, alu_result, ex_result;
  logic        active, redirect_raw, busy, capture, squash_reg;

  logic        mem_write_reg, mem_read_reg, reg_write_reg;
  logic [31:0] pc_mem_reg, pc_4_reg, alu_out_reg, rs2_reg;
  logic [1:0]  rf_wr_sel_reg;
  logic [4:0]  rd_reg;

  assign src_a = ex.DR_SRC_SEL[1] ? ex.DR_PC  : ex.DR_RS1;
  assign src_b = ex.DR_SRC_SEL[0] ? ex.DR_IMM : ex.DR_RS2;

  otter_alu u_alu (
    .src_a   (src_a),
    .src_b   (src_b),
    .alu_fun (ex.DR_ALU_FUN),
    .result  (alu_result)
  );

  // A squashed slot is the wrong-path instruction behind a redirect.
  assign active = ex.DR_VALID && !squash_reg;

  always_comb begin
    redirect_raw = 1'b0;
    case (ex.DR_JUMP)
      JUMP_BRANCH: redirect_raw = branch_taken(ex.DR_IR[14:12], ex.DR_RS1, ex.DR_RS2);
      JUMP_JAL:    redirect_raw = 1'b1;
      JUMP_JALR:   redirect_raw = 1'b1;
      default:     redirect_raw = 1'b0;
    endcase
  end

  assign ex.EX_REDIRECT = EX_RESET_N && active && redirect_raw;
  assign ex.EX_TARGET   = (ex.DR_JUMP == JUMP_JALR) ? ((ex.DR_RS1 + ex.DR_IMM) & ~32'd1)
                                                    : (ex.DR_PC + ex.DR_IMM);

`ifdef OTTER_EX_MUL_EN
  localparam int MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;

  mul_state_t  state_reg, state_next;
  logic        mul_start, mul_load, mul_step, busy_raw;
  logic [31:0] mcand_reg, mplier_reg, acc_reg, partial;
  logic [5:0]  step_cnt_reg;

  assign mul_start = active && (ex.DR_ALU_FUN == ALU_MUL);

  always_ff @(posedge EX_CLOCK or negedge EX_RESET_N) begin
    if (!EX_RESET_N) state_reg <= MUL_IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MUL_IDLE: if (mul_start) state_next = MUL_RUN;
      MUL_RUN:  if (step_cnt_reg == 6'(MUL_STEPS - 1)) state_next = MUL_DONE;
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  always_comb begin
    mul_load = 1'b0;
    mul_step = 1'b0;
    busy_raw = 1'b0;
    case (state_reg)
      MUL_IDLE: begin
        mul_load = mul_start;
        busy_raw = mul_start;
      end
      MUL_RUN: begin
        mul_step = 1'b1;
        busy_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift-add: each step folds the low multiplier bits into the accumulator.
  always_comb begin
    partial = acc_reg;
    for (int b = 0; b < MUL_BITS_PER_CYCLE; b++) begin
      if (mplier_reg[b]) partial = partial + (mcand_reg << b);
    end
  end

  always_ff @(posedge EX_CLOCK or negedge EX_RESET_N) begin
    if (!EX_RESET_N) begin
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      step_cnt_reg <= '0;
    end else if (mul_load) begin
      mcand_reg    <= src_a;
      mplier_reg   <= src_b;
      acc_reg      <= '0;
      step_cnt_reg <= '0;
    end else if (mul_step) begin
      mcand_reg    <= mcand_reg << MUL_BITS_PER_CYCLE;
      mplier_reg   <= mplier_reg >> MUL_BITS_PER_CYCLE;
      acc_reg      <= partial;
      step_cnt_reg <= step_cnt_reg + 6'd1;
    end
  end

  assign busy      = EX_RESET_N && busy_raw;
  assign ex_result = (ex.DR_ALU_FUN == ALU_MUL) ? acc_reg : alu_result;
`else
  assign busy      = 1'b0;
  assign ex_result = alu_result;
`endif

  assign ex.EX_BUSY = busy;
  assign capture    = active && !busy;

  always_ff @(posedge EX_CLOCK or negedge EX_RESET_N) begin
    if (!EX_RESET_N) begin
      squash_reg    <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      reg_write_reg <= 1'b0;
      pc_mem_reg    <= '0;
      pc_4_reg      <= '0;
      alu_out_reg   <= '0;
      rs2_reg       <= '0;
      rf_wr_sel_reg <= '0;
      rd_reg        <= '0;
    end else begin
      squash_reg <= ex.EX_REDIRECT;
      if (capture) begin
        mem_write_reg <= ex.DR_memWrite;
        mem_read_reg  <= ex.DR_memRead2;
        reg_write_reg <= ex.DR_REG_WRITE;
        pc_mem_reg    <= ex.DR_IR;
        pc_4_reg      <= ex.DR_PC + 32'd4;
        alu_out_reg   <= ex_result;
        rs2_reg       <= ex.DR_RS2;
        rf_wr_sel_reg <= ex.DR_RF_WR_SEL;
        rd_reg        <= ex.DR_RD;
      end else begin
        // Bubble: kill side effects, leave the data fields as they were.
        mem_write_reg <= 1'b0;
        mem_read_reg  <= 1'b0;
        reg_write_reg <= 1'b0;
        rd_reg        <= '0;
      end
    end
  end

  assign ex.ER_memWrite  = mem_write_reg;
  assign ex.ER_memRead2  = mem_read_reg;
  assign ex.ER_REG_WRITE = reg_write_reg;
  assign ex.ER_PC_MEM    = pc_mem_reg;
  assign ex.ER_PC_4      = pc_4_reg;
  assign ex.ER_ALU_OUT   = alu_out_reg;
  assign ex.ER_RS2       = rs2_reg;
  assign ex.ER_RF_WR_SEL = rf_wr_sel_reg;
  assign ex.EX_MS_RD     = rd_reg;

endmodule
